aes_key_expand: RTL and testbench



---
 rtl/aes_key_expand.sv | 141 ++++++++++++++
 tb/tb_aes_key_expand.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - AES-128 key schedule, one round key per clock
module aes_key_expand (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [127:0]  key_in,
    output logic          busy,
    output logic          done,
    output logic          key_valid,
    output logic [1407:0] round_keys
);

    // Forward S-box, row 0x0_ in the most significant 128 bits.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

    state_t        state, state_next;
    logic [3:0]    rnd;
    logic [3:0]    prev_idx;
    logic [127:0]  slot [0:10];
    logic [127:0]  prev_rk;
    logic [127:0]  next_rk;
    logic [31:0]   rot_sub;
    logic [7:0]    rcon;
    logic [31:0]   t_word;
    logic [31:0]   w0, w1, w2, w3;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EXPAND;
            EXPAND:  if (rnd == 4'd10) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == EXPAND);
    end

    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        prev_idx = rnd - 4'd1;
        prev_rk  = (prev_idx <= 4'd10) ? slot[prev_idx] : '0;
        // RotWord folded into the byte order of the S-box lookups.
        rot_sub  = {sbox(prev_rk[23:16]), sbox(prev_rk[15:8]),
                    sbox(prev_rk[7:0]),   sbox(prev_rk[31:24])};
        t_word   = rot_sub ^ {rcon, 24'h000000};
        w0       = prev_rk[127:96] ^ t_word;
        w1       = w0 ^ prev_rk[95:64];
        w2       = w1 ^ prev_rk[63:32];
        w3       = w2 ^ prev_rk[31:0];
        next_rk  = {w0, w1, w2, w3};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd       <= 4'd0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                slot[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    slot[0]   <= key_in;
                    rnd       <= 4'd1;
                    key_valid <= 1'b0;
                end
            end else begin
                for (int i = 1; i < 11; i++) begin
                    if (rnd == 4'(i)) begin
                        slot[i] <= next_rk;
                    end
                end
                if (rnd == 4'd10) begin
                    done      <= 1'b1;
                    key_valid <= 1'b1;
                end else begin
                    rnd <= rnd + 4'd1;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 11; g++) begin : g_out
            assign round_keys[128*g +: 128] = slot[g];
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed and random checks of aes_key_expand
module tb_aes_key_expand;

    logic          clk;
    logic          rst;
    logic          start;
    logic [127:0]  key_in;
    logic          busy;
    logic          done;
    logic          key_valid;
    logic [1407:0] round_keys;

    int errors;
    int checks;
    logic [7:0] sb [256];

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_expand dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .key_valid  (key_valid),
        .round_keys (round_keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] ref_expand(input logic [127:0] key);
        logic [1407:0] r;
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[128*(i/4) + 32*(3 - i%4) +: 32] = w[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_proto(input string tag, input logic [2:0] exp);
        checks++;
        assert ({busy, done, key_valid} === exp) else begin
            errors++;
            $error("FAIL %s: busy/done/key_valid=%b expected %b", tag, {busy, done, key_valid}, exp);
        end
    endtask

    task automatic check_rk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1407:0] exp);
        checks++;
        assert (round_keys === exp) else begin
            errors++;
            $error("FAIL %s: round_keys got %h expected %h", tag, round_keys, exp);
        end
    endtask

    // Start an expansion and follow it through the done cycle.
    task automatic run_key(input logic [127:0] key, input bit ign);
        start  = 1'b1;
        key_in = key;
        tick();
        start  = 1'b0;
        key_in = ~key;
        check_proto("accept", 3'b100);
        check_rk("slot0", round_keys[127:0], key);
        for (int c = 1; c <= 10; c++) begin
            if (ign && (c == 3 || c == 7)) start = 1'b1;
            tick();
            start = 1'b0;
            check_proto(c == 10 ? "done_cycle" : "expanding", c == 10 ? 3'b011 : 3'b100);
        end
        check_all("schedule", ref_expand(key));
    endtask

    initial begin
        logic [127:0] rkey;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        build_sbox();

        tick();
        tick();
        check_proto("reset_held", 3'b000);
        check_all("reset_keys", '0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_proto("idle_after_reset", 3'b000);
        end
        check_all("idle_keys", '0);

        run_key(KEY_A1, 1'b0);
        check_rk("a1_slot1", round_keys[255:128], A1_R1);
        check_rk("a1_slot10", round_keys[1407:1280], A1_R10);
        tick();
        check_proto("after_done", 3'b001);
        check_rk("a1_hold", round_keys[1407:1280], A1_R10);

        run_key(KEY_A1, 1'b1);
        check_rk("ign_slot10", round_keys[1407:1280], A1_R10);
        run_key(KEY_SEQ, 1'b0);
        check_rk("b2b_slot10", round_keys[1407:1280], SEQ_R10);
        tick();
        check_proto("b2b_after", 3'b001);

        start  = 1'b1;
        key_in = KEY_SEQ;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b1;
        #1;
        check_proto("mid_reset_async", 3'b000);
        check_all("mid_reset_keys", '0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_proto("no_done_after_abort", 3'b000);
        end
        check_all("abort_keys", '0);
        run_key(KEY_A1, 1'b0);
        check_rk("post_reset_slot10", round_keys[1407:1280], A1_R10);
        tick();

        for (int n = 0; n < 1000; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_key(rkey, n[0]);
        end
        tick();
        check_proto("final_idle", 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
